mc6502_bus_bridge: RTL
======================

// Module: mc6502_bus_bridge
// PURPOSE
//  Memory-side bus bridge directly downstream of the MC6502 core's address/data/rw bus.
//  - Decodes each CPU access into one of three regions: internal RAM, I/O page, or the external bus.
//  - Inserts wait states by withholding cpu_rdy, and runs a req/ack handshake to external memory.
//  - A timeout terminates hung external cycles, so a dead device cannot stall the core forever.
// PARAMETERS
//  RAM_AW   10     internal RAM address width; RAM spans 0x0000..2^RAM_AW-1
//  IO_PAGE  8'hD0  high address byte selecting the I/O page
//  IO_WAIT  2      setup cycles inserted before ext_req for I/O page accesses (0 allowed)
//  TO_W     8      width of the timeout counter
//  TIMEOUT  255    ext_req cycles without ack before abort (1..2^TO_W-1)
// PORTS
//  clk        in   1   single clock, all logic on rising edge
//  rst        in   1   synchronous reset, active-high
//  cpu_valid  in   1   CPU presents an access; held with ab/rw/wdata until cpu_rdy
//  cpu_ab     in   16  CPU address
//  cpu_rw     in   1   1=read, 0=write
//  cpu_wdata  in   8   write data
//  cpu_rdy    out  1   one-cycle completion pulse
//  cpu_rdata  out  8   read data; valid in the cpu_rdy cycle, held until the next completion
//  ext_req    out  1   external request, registered; held until ack or timeout
//  ext_addr   out  16  latched address
//  ext_we     out  1   latched !cpu_rw
//  ext_wdata  out  8   latched write data
//  ext_ack    in   1   external completion; sampled only while ext_req=1
//  ext_rdata  in   8   external read data, sampled on the ack cycle
//  err_clr    in   1   clears bus_err
//  bus_err    out  1   sticky flag, set by a timeout
// BEHAVIOUR
//  Reset: state=IDLE. cpu_rdy=0, cpu_rdata=8'h00, ext_req=0, ext_addr=0, ext_we=0, ext_wdata=0, bus_err=0, counters=0.
//  Reset mid-operation: ext_req drops at that edge; the pending access is discarded with no rdy.
//  FSM states: IDLE, RAM, IOWAIT, EXT, DONE.
//  Accept: cycle T with state=IDLE and cpu_valid=1. At T, latch ab, rw and wdata into the ext_* registers.
//  Decode, in priority order:
//   1. RAM if cpu_ab[15:RAM_AW]==0.
//   2. I/O if cpu_ab[15:8]==IO_PAGE. RAM wins if the two overlap.
//   3. Otherwise EXT.
//  RAM access:
//   - Write: RAM is written at edge T.
//   - Read: RAM is read synchronously at edge T; data goes to cpu_rdata at edge T+1.
//   - IDLE->RAM->IDLE; cpu_rdy=1 in cycle T+1 only.
//  I/O access:
//   - IDLE->IOWAIT for IO_WAIT cycles (wait counter loaded at T, decremented each cycle).
//   - Then EXT, with ext_req=1 from cycle T+1+IO_WAIT.
//   - IO_WAIT=0 goes straight to EXT.
//  External access:
//   - IDLE->EXT, ext_req=1 from cycle T+1.
//   - In EXT, ext_req and ext_addr/we/wdata are held stable.
//  Ack: on the first cycle A with ext_req=1 and ext_ack=1:
//   - Capture ext_rdata (reads only); writes leave cpu_rdata unchanged.
//   - ext_req=0 from A+1; EXT->DONE.
//   - cpu_rdy=1 in cycle A+1; DONE->IDLE.
//  Timeout:
//   - The timeout counter clears on entry to EXT and increments each EXT cycle with no ack.
//   - When it reaches TIMEOUT, exit as for ack but with cpu_rdata=8'hFF (reads) and bus_err<=1.
//   - Ack in the same cycle as the terminal count: ack wins, no error.
//  Other boundary cases:
//   - ext_ack while ext_req=0 is ignored.
//   - cpu_valid dropped mid-access: the access still completes and rdy still pulses.
//   - cpu_valid is not sampled outside IDLE.
//   - Back-to-back: a new access may be accepted in the cycle after cpu_rdy (state IDLE). Minimum 2 cycles per access.
//  bus_err: set by a timeout, cleared by err_clr. If both occur in the same cycle, set wins.
//  Address arithmetic: no increment or wrap; ext_addr is exactly cpu_ab as latched.
// TESTING
//  1. RAM write then read: write 0x5A at 0x0123, then read 0x0123 -> rdy at T+1 with rdata=0x5A; ext_req stays 0 throughout.
//  2. I/O read at 0xD004, IO_WAIT=2, ack 3 cycles after req with ext_rdata=0x3C:
//     -> ext_req first at T+3, rdy at A+1 with rdata=0x3C, ext_addr=0xD004.
//  3. Ext write 0x8000<-0x77 with ack on the first req cycle -> ext_we=1, ext_wdata=0x77, rdy at T+2, cpu_rdata unchanged.
//  4. Ext read at 0xFFFC, no ack, TIMEOUT=4 -> ext_req high for exactly 4 cycles, rdata=0xFF, bus_err=1 and sticky; err_clr -> bus_err=0.
//  5. Ack coincident with the terminal count -> normal completion with ext_rdata, bus_err stays 0.
//  6. rst asserted while ext_req=1 -> ext_req=0 and state IDLE after that edge, no rdy pulse; the next access completes normally.

Source files
------------

// File: rtl/mc6502_bus_bridge.sv
// Bus bridge between the MC6502 core and memory: decodes each access to internal RAM,
// the I/O page or the external bus, inserts wait states, and aborts hung external cycles.
module mc6502_bus_bridge #(
    parameter int          RAM_AW  = 10,
    parameter logic [7:0]  IO_PAGE = 8'hD0,
    parameter int          IO_WAIT = 2,
    parameter int          TO_W    = 8,
    parameter int          TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_valid,
    input  logic [15:0] cpu_ab,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_rdy,
    output logic [7:0]  cpu_rdata,
    output logic        ext_req,
    output logic [15:0] ext_addr,
    output logic        ext_we,
    output logic [7:0]  ext_wdata,
    input  logic        ext_ack,
    input  logic [7:0]  ext_rdata,
    input  logic        err_clr,
    output logic        bus_err
);

    // state  | meaning
    // IDLE   | waiting for cpu_valid; latches the access on accept
    // RAM    | internal RAM cycle, cpu_rdy high
    // IOWAIT | I/O setup cycles before ext_req
    // EXT    | ext_req high, waiting for ack or timeout
    // DONE   | external cycle finished, cpu_rdy high
    typedef enum logic [2:0] {
        S_IDLE,
        S_RAM,
        S_IOWAIT,
        S_EXT,
        S_DONE
    } state_t;

    localparam int              WAIT_W    = (IO_WAIT > 1) ? $clog2(IO_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((IO_WAIT > 0) ? IO_WAIT - 1 : 0);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic [7:0]          rdata_reg;
    logic [7:0]          ram_q;
    logic [7:0]          ram [0:(1 << RAM_AW) - 1];

    logic                is_ram;
    logic                is_io;
    logic                accept;
    logic [RAM_AW-1:0]   ram_idx;

    assign is_ram  = (cpu_ab[15:RAM_AW] == '0);
    assign is_io   = (cpu_ab[15:8] == IO_PAGE);
    assign accept  = (state == S_IDLE) && cpu_valid;
    assign ram_idx = cpu_ab[RAM_AW-1:0];

    // RAM read data arrives one edge after accept, so bypass it in the rdy cycle.
    assign cpu_rdata = (state == S_RAM && !ext_we) ? ram_q : rdata_reg;

    always_ff @(posedge clk) begin
        if (!rst && accept && is_ram) begin
            if (!cpu_rw) begin
                ram[ram_idx] <= cpu_wdata;
            end
            ram_q <= ram[ram_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            to_cnt    <= '0;
            rdata_reg <= 8'h00;
            cpu_rdy   <= 1'b0;
            ext_req   <= 1'b0;
            ext_addr  <= 16'h0000;
            ext_we    <= 1'b0;
            ext_wdata <= 8'h00;
            bus_err   <= 1'b0;
        end else begin
            cpu_rdy <= 1'b0;
            if (err_clr) begin
                bus_err <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (cpu_valid) begin
                        ext_addr  <= cpu_ab;
                        ext_we    <= !cpu_rw;
                        ext_wdata <= cpu_wdata;
                        if (is_ram) begin
                            state   <= S_RAM;
                            cpu_rdy <= 1'b1;
                        end else if (is_io && IO_WAIT > 0) begin
                            state    <= S_IOWAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state   <= S_EXT;
                            ext_req <= 1'b1;
                            to_cnt  <= '0;
                        end
                    end
                end
                S_RAM: begin
                    if (!ext_we) begin
                        rdata_reg <= ram_q;
                    end
                    state <= S_IDLE;
                end
                S_IOWAIT: begin
                    if (wait_cnt == '0) begin
                        state   <= S_EXT;
                        ext_req <= 1'b1;
                        to_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_EXT: begin
                    // Ack is checked first so it wins over a coincident terminal count.
                    if (ext_ack) begin
                        ext_req <= 1'b0;
                        cpu_rdy <= 1'b1;
                        state   <= S_DONE;
                        if (!ext_we) begin
                            rdata_reg <= ext_rdata;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        ext_req <= 1'b0;
                        cpu_rdy <= 1'b1;
                        state   <= S_DONE;
                        bus_err <= 1'b1;
                        if (!ext_we) begin
                            rdata_reg <= 8'hFF;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
